// File: rtl/execution_stage_pipelined.sv
// MIPS EX stage with forwarding muxes, an iterative multu/divu unit driving HI/LO,
// and a registered EX/MEM output stage.
module execution_stage_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      flush,
  input  logic                      RegDst,
  input  logic                      ALUSrc,
  input  logic [1:0]                ALUOp,
  input  logic                      MemtoReg,
  input  logic                      RegWrite,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic                      Branch,
  input  logic [DATA_WIDTH-1:0]     pc_plus4,
  input  logic [DATA_WIDTH-1:0]     read_data1,
  input  logic [DATA_WIDTH-1:0]     read_data2,
  input  logic [DATA_WIDTH-1:0]     sign_extended,
  input  logic [REG_ADDR_WIDTH-1:0] inst_20_16,
  input  logic [REG_ADDR_WIDTH-1:0] inst_15_11,
  input  logic [1:0]                forward_a,
  input  logic [1:0]                forward_b,
  input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
  output logic                      stall_out,
  output logic                      muldiv_busy,
  output logic                      valid_out,
  output logic                      zero_out,
  output logic [DATA_WIDTH-1:0]     add_result,
  output logic [DATA_WIDTH-1:0]     alu_result,
  output logic [DATA_WIDTH-1:0]     read_data2_out,
  output logic [REG_ADDR_WIDTH-1:0] mux_out,
  output logic                      MemtoReg_out,
  output logic                      RegWrite_out,
  output logic                      MemRead_out,
  output logic                      MemWrite_out,
  output logic                      Branch_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU
  } op_e;

  op_e                   op;
  logic [DATA_WIDTH-1:0] op_a, fwd_b, op_b, alu_val, br_target;
  logic                  is_md, capture, start;

  logic                  busy_q, is_div_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] work_hi_q, work_lo_q, opnd_q, hi_q, lo_q;
  logic [DATA_WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [DATA_WIDTH-1:0] step_hi, step_lo;

  logic                      valid_q, zero_q;
  logic [DATA_WIDTH-1:0]     add_q, alu_q, rd2_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q;
  logic [4:0]                ctrl_q;

  function automatic logic [DATA_WIDTH-1:0] fwd_sel(input logic [DATA_WIDTH-1:0] rf,
                                                    input logic [1:0]            sel,
                                                    input logic [DATA_WIDTH-1:0] wb,
                                                    input logic [DATA_WIDTH-1:0] mem);
    case (sel)
      2'b01:   return wb;
      2'b10:   return mem;
      default: return rf;
    endcase
  endfunction

  always_comb begin
    op = OP_ADD;
    case (ALUOp)
      2'b01: op = OP_SUB;
      2'b10: begin
        case (sign_extended[5:0])
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b011001: op = OP_MULTU;
          6'b011011: op = OP_DIVU;
          default:   op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  always_comb begin
    op_a      = fwd_sel(read_data1, forward_a, fwd_wb_data, fwd_mem_data);
    fwd_b     = fwd_sel(read_data2, forward_b, fwd_wb_data, fwd_mem_data);
    op_b      = ALUSrc ? sign_extended : fwd_b;
    is_md     = (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MFHI) || (op == OP_MFLO);
    stall_out = in_valid & busy_q & is_md;
    capture   = in_valid & ~stall_out & ~flush;
    start     = capture & ((op == OP_MULTU) || (op == OP_DIVU));
    br_target = pc_plus4 + (sign_extended << 2);
    case (op)
      OP_SUB:  alu_val = op_a - op_b;
      OP_AND:  alu_val = op_a & op_b;
      OP_OR:   alu_val = op_a | op_b;
      OP_SLT:  alu_val = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MFHI: alu_val = hi_q;
      OP_MFLO: alu_val = lo_q;
      OP_MULTU, OP_DIVU: alu_val = '0;
      default: alu_val = op_a + op_b;
    endcase
  end

  // One iteration per cycle: shift-add multiply shifts {hi,lo} right;
  // restoring divide shifts the dividend out of lo into the remainder in hi.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_hi_q, work_lo_q[DATA_WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_trial[DATA_WIDTH]) begin
        step_hi = div_trial[DATA_WIDTH-1:0];
        step_lo = {work_lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[DATA_WIDTH-1:0];
        step_lo = {work_lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (busy_q) begin
        work_hi_q <= step_hi;
        work_lo_q <= step_lo;
        cnt_q     <= cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          busy_q <= 1'b0;
          hi_q   <= step_hi;
          lo_q   <= step_lo;
        end
      end
      if (start) begin
        busy_q    <= 1'b1;
        is_div_q  <= (op == OP_DIVU);
        cnt_q     <= '0;
        work_hi_q <= '0;
        work_lo_q <= (op == OP_DIVU) ? op_a : op_b;
        opnd_q    <= (op == OP_DIVU) ? op_b : op_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      add_q   <= '0;
      alu_q   <= '0;
      rd2_q   <= '0;
      dst_q   <= '0;
      ctrl_q  <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      zero_q  <= (alu_val == '0);
      add_q   <= br_target;
      alu_q   <= alu_val;
      rd2_q   <= fwd_b;
      dst_q   <= RegDst ? inst_15_11 : inst_20_16;
      ctrl_q  <= {MemtoReg, RegWrite, MemRead, MemWrite, Branch};
    end else begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign muldiv_busy    = busy_q;
  assign valid_out      = valid_q;
  assign zero_out       = zero_q;
  assign add_result     = add_q;
  assign alu_result     = alu_q;
  assign read_data2_out = rd2_q;
  assign mux_out        = dst_q;
  assign {MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out} = ctrl_q;

endmodule
